bcd_display_ctrl: RTL and testbench
===================================

BCD_DISPLAY_CTRL -- requirements
Module: bcd_display_ctrl

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 16'd50000, which sets the number of clk cycles each display digit stays active (legal range 2..65535).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  the reset, asynchronous and active-low.
REQ-004 The block SHALL have port bin_in  input  8  the unsigned binary value to convert, sampled only on an accepted handshake.
REQ-005 The block SHALL have port in_valid  input  1  the request strobe for bin_in.
REQ-006 The block SHALL have port in_ready  output  1  which is high only in state IDLE.
REQ-007 The block SHALL have port busy  output  1  which is high whenever state is not IDLE.
REQ-008 The block SHALL have port bcd_out  output  10  the registered result {hundreds[1:0], tens[3:0], ones[3:0]}.
REQ-009 The block SHALL have port bcd_valid  output  1  a one-cycle pulse marking that a new bcd_out has been produced.
REQ-010 The block SHALL have port seg  output  7  the active-low segments {g,f,e,d,c,b,a} of the active digit.
REQ-011 The block SHALL have port an  output  3  the active-low one-hot digit enable, where an[0]=ones, an[1]=tens and an[2]=hundreds.

Function
REQ-012 The converter FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE, when in_valid&&in_ready is true at a rising edge, the block SHALL load the 18-bit work register {10'b0, bin_in}, clear the shift count to 0, and enter SHIFT.
REQ-014 In SHIFT, on each cycle the block SHALL first add 3 to every 4-bit BCD field of the work register whose value is >=5, then shift the whole register left by 1.
REQ-015 After the 8th shift (count==7), the FSM SHALL enter DONE; otherwise it SHALL increment count and stay in SHIFT.
REQ-016 On the edge that enters DONE, bcd_out SHALL be loaded from work[17:8], truncated to 10 bits.
REQ-017 In DONE, bcd_valid SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-018 Latency SHALL be as follows: if the handshake occurs at edge T, SHIFT occupies cycles T+1..T+8, DONE with bcd_valid=1 is cycle T+9, and in_ready is high again in cycle T+10.
REQ-019 in_valid asserted during SHIFT or DONE SHALL be ignored, with no queuing; bin_in changes during conversion SHALL have no effect.
REQ-020 bcd_out SHALL hold its value until the next DONE.
REQ-021 The scan counter SHALL count 0..SCAN_DIV-1 and then wrap to 0; on each wrap, the digit index SHALL advance 0->1->2->0.
REQ-022 an SHALL be driven as 3'b110, 3'b101 and 3'b011 for digit index 0, 1 and 2 respectively.
REQ-023 The displayed digits SHALL be taken from bcd_out: ones for index 0, tens for index 1, and {2'b00, hundreds} for index 2.
REQ-024 Decimal digits 0-9 SHALL be encoded on seg as 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000; any value >9 SHALL be encoded as blank (1111111).
REQ-025 Leading-zero blanking SHALL apply as follows: the hundreds digit is blank when hundreds==0, the tens digit is blank when hundreds==0 and tens==0, and the ones digit is never blanked.
REQ-026 The scan SHALL run continuously and independently of the converter FSM; a bcd_out update takes effect on the next displayed digit with no scan restart.
REQ-027 All outputs SHALL be glitch-free registered or decoded from registers, with no combinational path from in_valid to any output other than via state.

Reset
REQ-028 While rst_n is low, the block SHALL hold state=IDLE, count=0, work=0, bcd_out=0, bcd_valid=0, scan counter=0 and digit index=0, so that in_ready=1, busy=0, an=3'b110 and seg=1000000.
REQ-029 Reset asserted mid-SHIFT or in DONE SHALL abandon the conversion; bcd_out SHALL read 0 and no bcd_valid pulse SHALL be emitted.
REQ-030 The first handshake SHALL be accepted at the first rising edge after rst_n deasserts.

Verification
REQ-031 The bench SHALL apply bin_in=8'd255 with a one-cycle in_valid, after which bcd_valid SHALL pulse 9 cycles later with bcd_out=10'b10_0101_0101 (hundreds=2, tens=5, ones=5) and in_ready low in between.
REQ-032 The bench SHALL apply bin_in=8'd0 and then 8'd99 with SCAN_DIV=4, after which the display for 0 SHALL show only an[0] digit '0' with tens and hundreds blank, and the display for 99 SHALL show '9','9' with hundreds blank, each digit held 4 cycles.
REQ-033 The bench SHALL hold in_valid high continuously with bin_in incrementing every cycle, after which accepts SHALL occur every 10 cycles, each result SHALL match the value sampled at its accept edge, and intermediate values SHALL be ignored.
REQ-034 The bench SHALL assert rst_n low in the 4th SHIFT cycle of bin_in=8'd200, after which there SHALL be no bcd_valid pulse, bcd_out=0, and the converter SHALL be IDLE with in_ready=1 immediately; a new request of 8'd7 SHALL complete with bcd_out=10'd7.
REQ-035 The bench SHALL sweep all 256 inputs, comparing hundreds*100+tens*10+ones to bin_in and checking tens<=9 and ones<=9, with no mismatches permitted.

Source files
------------

// File: rtl/bcd_display_ctrl.sv
// bcd_display_ctrl: 8-bit binary to BCD converter (shift-add-3) driving a
// multiplexed 3-digit active-low seven-segment display with leading-zero blanking.
module bcd_display_ctrl #(
  parameter logic [15:0] SCAN_DIV = 16'd50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] bin_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       busy,
  output logic [9:0] bcd_out,
  output logic       bcd_valid,
  output logic [6:0] seg,
  output logic [2:0] an
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t      state;
  logic [2:0]  count;
  logic [17:0] work, adj, shifted;
  logic [3:0]  ones_adj, tens_adj;
  logic [15:0] scan_cnt;
  logic [1:0]  digit;
  logic [3:0]  digit_val;
  logic        blank;
  assign in_ready = state == IDLE;
  assign busy     = state != IDLE;
  always_comb begin
    ones_adj = work[11:8]  >= 4'd5 ? work[11:8]  + 4'd3 : work[11:8];
    tens_adj = work[15:12] >= 4'd5 ? work[15:12] + 4'd3 : work[15:12];
    adj      = {work[17:16], tens_adj, ones_adj, work[7:0]};
    shifted  = adj << 1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= 3'd0;
      work      <= 18'd0;
      bcd_out   <= 10'd0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          work  <= {10'b0, bin_in};
          count <= 3'd0;
          state <= SHIFT;
        end
        SHIFT: begin
          work <= shifted;
          if (count == 3'd7) begin
            state     <= DONE;
            bcd_out   <= shifted[17:8];
            bcd_valid <= 1'b1;
          end else begin
            count <= count + 3'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // Scan runs free of the converter so a new result never restarts the sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= 16'd0;
      digit    <= 2'd0;
    end else if (scan_cnt == SCAN_DIV - 16'd1) begin
      scan_cnt <= 16'd0;
      digit    <= digit == 2'd2 ? 2'd0 : digit + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 16'd1;
    end
  end
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction
  always_comb begin
    digit_val = digit == 2'd0 ? bcd_out[3:0] : digit == 2'd1 ? bcd_out[7:4] : {2'b00, bcd_out[9:8]};
    blank     = (digit == 2'd2 && bcd_out[9:8] == 2'd0) ||
                (digit == 2'd1 && bcd_out[9:8] == 2'd0 && bcd_out[7:4] == 4'd0);
    an        = digit == 2'd0 ? 3'b110 : digit == 2'd1 ? 3'b101 : 3'b011;
    seg       = blank ? 7'b1111111 : seg_decode(digit_val);
  end
endmodule

// File: tb/tb_bcd_display_ctrl.sv
// tb_bcd_display_ctrl: scoreboard bench; expected results come from decimal
// arithmetic on accepted values, display expectations from a cycle-count model.
module tb_bcd_display_ctrl;
  localparam int DIV = 4;
  localparam logic [6:0] SEG_TBL [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic [7:0] bin_in = 8'd0;
  logic       in_ready, busy, bcd_valid;
  logic [9:0] bcd_out;
  logic [6:0] seg;
  logic [2:0] an;
  typedef struct { int val; int due; } exp_t;
  exp_t q[$];
  exp_t e;
  int cyc = 0, busy_until = 0, ticks = 0, model_val = 0;
  int checks = 0, errors = 0;

  bcd_display_ctrl #(.SCAN_DIV(16'(DIV))) dut (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .in_valid(in_valid), .in_ready(in_ready),
    .busy(busy), .bcd_out(bcd_out), .bcd_valid(bcd_valid), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  function automatic int enc(input int v);
    return (v / 100) * 256 + ((v / 10) % 10) * 16 + v % 10;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model of acceptance: one request per 10 cycles, others dropped.
  always @(posedge clk) begin
    if (!rst_n) begin
      busy_until = 0;
      ticks = 0;
      q.delete();
    end else begin
      if (in_valid && cyc >= busy_until) begin
        q.push_back('{val: int'(bin_in), due: cyc + 9});
        busy_until = cyc + 10;
      end
      ticks++;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      model_val = 0;
      ticks = 0;
      check("rst_bcd_valid", int'(bcd_valid), 0);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_bcd_out", int'(bcd_out), 0);
      check("rst_an", int'(an), 6);
      check("rst_seg", int'(seg), 64);
    end else begin
      if (bcd_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_valid: got bcd_valid=1 expected 0 at cycle %0d", cyc);
        end else begin
          e = q.pop_front();
          check("latency", cyc, e.due);
          check("bcd_out", int'(bcd_out), enc(e.val));
          check("decimal_sum", int'(bcd_out[9:8]) * 100 + int'(bcd_out[7:4]) * 10 + int'(bcd_out[3:0]), e.val);
          check("tens_le_9", int'(bcd_out[7:4] <= 4'd9), 1);
          check("ones_le_9", int'(bcd_out[3:0] <= 4'd9), 1);
          model_val = e.val;
        end
      end
      if (q.size() > 0 && q[0].due < cyc) begin
        check("missing_valid", cyc, q[0].due);
        void'(q.pop_front());
      end
      check("in_ready", int'(in_ready), int'(cyc >= busy_until));
      check("busy", int'(busy), int'(cyc < busy_until));
      check("bcd_hold", int'(bcd_out), enc(model_val));
      begin
        int d, h, t, o, v;
        bit blank;
        d = (ticks / DIV) % 3;
        h = model_val / 100;
        t = (model_val / 10) % 10;
        o = model_val % 10;
        v = d == 0 ? o : d == 1 ? t : h;
        blank = d == 2 ? h == 0 : d == 1 ? (h == 0 && t == 0) : 1'b0;
        check("an", int'(an), d == 0 ? 6 : d == 1 ? 5 : 3);
        check("seg", int'(seg), blank ? 127 : int'(SEG_TBL[v]));
      end
    end
  end

  task automatic req(input logic [7:0] v);
    in_valid = 1'b1;
    bin_in = v;
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    idle(3);
    rst_n = 1'b1;
    req(8'd255);
    idle(12);
    req(8'd0);
    idle(20);
    req(8'd99);
    idle(20);
    in_valid = 1'b1;
    bin_in = 8'($urandom);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #2;
      bin_in = bin_in + 8'd1;
    end
    in_valid = 1'b0;
    idle(12);
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      bin_in = 8'($urandom);
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    idle(12);
    req(8'd200);
    idle(3);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    req(8'd7);
    idle(12);
    for (int v = 0; v < 256; v++) begin
      req(8'(v));
      idle(9);
    end
    idle(12);
    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
